// File: rtl/barrel_motion.sv
// Barrel motion/animation controller: spawns at the top platform, rolls the zig-zag
// platforms, drops at each edge and leaves through the floor edge. Advances on frame tick.
module barrel_motion #(
  parameter int SPAWN_X   = 320,
  parameter int SPAWN_Y   = 60,
  parameter int LEFT_X    = 40,
  parameter int RIGHT_X   = 600,
  parameter int PITCH     = 80,
  parameter int NUM_PLAT  = 6,
  parameter int ROLL_STEP = 2,
  parameter int FALL_STEP = 4,
  parameter int ANIM_DIV  = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       spawn,
  input  logic       kill,
  output logic [1:0] state,
  output logic [2:0] animation_state,
  output logic [9:0] posX,
  output logic [8:0] posY,
  output logic       busy,
  output logic       done
);

  // state      | meaning
  // ST_INITIAL | idle at spawn point, waiting for spawn
  // ST_ROLLING | moving horizontally along the current platform
  // ST_FALLING | dropping to the next platform, X held
  // ST_BAD     | never entered; recovers to ST_INITIAL
  typedef enum logic [1:0] {
    ST_INITIAL = 2'b00,
    ST_ROLLING = 2'b01,
    ST_FALLING = 2'b10,
    ST_BAD     = 2'b11
  } state_t;

  localparam int CNT_W  = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
  localparam int PLAT_W = (NUM_PLAT > 1) ? $clog2(NUM_PLAT) : 1;

  localparam logic [2:0]        AN_ROLL1  = 3'b000;
  localparam logic [2:0]        AN_FALL1  = 3'b100;
  localparam logic [9:0]        SX10      = 10'(SPAWN_X);
  localparam logic [9:0]        LX10      = 10'(LEFT_X);
  localparam logic [9:0]        RX10      = 10'(RIGHT_X);
  localparam logic [10:0]       LX11      = 11'(LEFT_X);
  localparam logic [10:0]       RX11      = 11'(RIGHT_X);
  localparam logic [10:0]       RS11      = 11'(ROLL_STEP);
  localparam logic [8:0]        SY9       = 9'(SPAWN_Y);
  localparam logic [8:0]        PITCH9    = 9'(PITCH);
  localparam logic [8:0]        FS9       = 9'(FALL_STEP);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(ANIM_DIV - 1);
  localparam logic [PLAT_W-1:0] PLAT_LAST = PLAT_W'(NUM_PLAT - 1);

  state_t              state_q, state_n;
  logic [2:0]          anim_q, anim_n, anim_adv;
  logic [9:0]          x_q, x_n;
  logic [8:0]          y_q, y_n, ny;
  logic [10:0]         nx;
  logic                dir_q, dir_n;     // 1 = rolling left
  logic [PLAT_W-1:0]   plat_q, plat_n;
  logic [CNT_W-1:0]    cnt_q, cnt_n, cnt_adv;
  logic [8:0]          tgt_q, tgt_n;
  logic                done_q, done_n;
  logic                busy_q;
  logic                at_edge;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_INITIAL;
      anim_q  <= AN_ROLL1;
      x_q     <= SX10;
      y_q     <= SY9;
      dir_q   <= 1'b0;
      plat_q  <= '0;
      cnt_q   <= '0;
      tgt_q   <= SY9;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_n;
      anim_q  <= anim_n;
      x_q     <= x_n;
      y_q     <= y_n;
      dir_q   <= dir_n;
      plat_q  <= plat_n;
      cnt_q   <= cnt_n;
      tgt_q   <= tgt_n;
      done_q  <= done_n;
      busy_q  <= (state_n != ST_INITIAL);
    end
  end

  always_comb begin
    state_n = state_q;
    anim_n  = anim_q;
    x_n     = x_q;
    y_n     = y_q;
    dir_n   = dir_q;
    plat_n  = plat_q;
    cnt_n   = cnt_q;
    tgt_n   = tgt_q;
    done_n  = 1'b0;

    nx = dir_q ? ({1'b0, x_q} - RS11) : ({1'b0, x_q} + RS11);
    ny = y_q + FS9;
    // Left-edge test is done before subtracting so an underflowing nx still counts as the edge.
    at_edge = dir_q ? ({1'b0, x_q} <= (LX11 + RS11)) : (nx >= RX11);

    if (cnt_q == CNT_LAST) begin
      cnt_adv  = '0;
      anim_adv = (state_q == ST_FALLING) ? {2'b10, ~anim_q[0]}
                                         : {1'b0, anim_q[1:0] + 2'd1};
    end else begin
      cnt_adv  = cnt_q + 1'b1;
      anim_adv = anim_q;
    end

    if (kill || state_q == ST_BAD) begin
      state_n = ST_INITIAL;
      anim_n  = AN_ROLL1;
      x_n     = SX10;
      y_n     = SY9;
      dir_n   = 1'b0;
      plat_n  = '0;
      cnt_n   = '0;
      tgt_n   = SY9;
    end else begin
      case (state_q)
        ST_INITIAL: begin
          if (spawn) begin
            state_n = ST_ROLLING;
            x_n     = SX10;
            y_n     = SY9;
            dir_n   = 1'b0;
            plat_n  = '0;
            anim_n  = AN_ROLL1;
            cnt_n   = '0;
          end
        end
        ST_ROLLING: begin
          if (tick) begin
            if (at_edge) begin
              if (plat_q != PLAT_LAST) begin
                x_n     = dir_q ? LX10 : RX10;
                state_n = ST_FALLING;
                tgt_n   = y_q + PITCH9;
                anim_n  = AN_FALL1;
                cnt_n   = '0;
              end else begin
                state_n = ST_INITIAL;
                done_n  = 1'b1;
                x_n     = SX10;
                y_n     = SY9;
                anim_n  = AN_ROLL1;
                cnt_n   = '0;
                dir_n   = 1'b0;
                plat_n  = '0;
                tgt_n   = SY9;
              end
            end else begin
              x_n    = nx[9:0];
              anim_n = anim_adv;
              cnt_n  = cnt_adv;
            end
          end
        end
        ST_FALLING: begin
          if (tick) begin
            y_n = ny;
            if (ny == tgt_q) begin
              state_n = ST_ROLLING;
              dir_n   = ~dir_q;
              plat_n  = plat_q + 1'b1;
              anim_n  = AN_ROLL1;
              cnt_n   = '0;
            end else begin
              anim_n = anim_adv;
              cnt_n  = cnt_adv;
            end
          end
        end
        default: state_n = ST_INITIAL;
      endcase
    end
  end

  assign state           = state_q;
  assign animation_state = anim_q;
  assign posX            = x_q;
  assign posY            = y_q;
  assign busy            = busy_q;
  assign done            = done_q;

endmodule

// File: tb/tb_barrel_motion.sv
// Bench for barrel_motion: a behavioural model feeds a scoreboard queue every cycle,
// and scenario tasks add directed checks of the documented motion milestones.
module tb_barrel_motion;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick = 1'b0;
  logic       spawn = 1'b0;
  logic       kill = 1'b0;
  logic [1:0] state;
  logic [2:0] animation_state;
  logic [9:0] posX;
  logic [8:0] posY;
  logic       busy;
  logic       done;
  logic [25:0] obs;

  int checks = 0;
  int failures = 0;

  logic [25:0] sb_q[$];
  logic [25:0] mon_exp;

  int m_state, m_anim, m_x, m_y, m_plat, m_cnt, m_tgt;
  bit m_dir, m_done;

  localparam logic [25:0] IDLE_VEC = {2'd0, 3'd0, 10'd320, 9'd60, 1'b0, 1'b0};

  barrel_motion dut (
    .clk(clk), .rst(rst), .tick(tick), .spawn(spawn), .kill(kill),
    .state(state), .animation_state(animation_state), .posX(posX), .posY(posY),
    .busy(busy), .done(done)
  );

  assign obs = {state, animation_state, posX, posY, busy, done};

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      mon_exp = sb_q.pop_front();
      checks++;
      if (obs !== mon_exp) begin
        failures++;
        $display("FAIL scoreboard t=%0t actual=%h expected=%h", $time, obs, mon_exp);
      end
    end
  end

  task automatic model_animate();
    if (m_cnt == 3) begin
      m_cnt = 0;
      if (m_state == 1) m_anim = (m_anim + 1) % 4;
      else m_anim = (m_anim == 4) ? 5 : 4;
    end else begin
      m_cnt++;
    end
  endtask

  task automatic model_update(input logic s, input logic k, input logic t, input logic r);
    int nx;
    m_done = 0;
    if (r || k) begin
      m_state = 0; m_anim = 0; m_x = 320; m_y = 60;
      m_dir = 0; m_plat = 0; m_cnt = 0; m_tgt = 60;
    end else if (m_state == 0) begin
      if (s) begin
        m_state = 1; m_x = 320; m_y = 60; m_dir = 0; m_plat = 0; m_anim = 0; m_cnt = 0;
      end
    end else if (t) begin
      if (m_state == 1) begin
        nx = m_dir ? m_x - 2 : m_x + 2;
        if ((!m_dir && nx >= 600) || (m_dir && nx <= 40)) begin
          if (m_plat < 5) begin
            m_x = m_dir ? 40 : 600;
            m_state = 2; m_tgt = m_y + 80; m_anim = 4; m_cnt = 0;
          end else begin
            m_state = 0; m_done = 1; m_x = 320; m_y = 60; m_anim = 0; m_cnt = 0;
          end
        end else begin
          m_x = nx;
          model_animate();
        end
      end else begin
        m_y = m_y + 4;
        if (m_y == m_tgt) begin
          m_state = 1; m_dir = !m_dir; m_plat++; m_anim = 0; m_cnt = 0;
        end else begin
          model_animate();
        end
      end
    end
  endtask

  task automatic step(input logic s, input logic k, input logic t, input logic r);
    @(negedge clk);
    #1;
    spawn = s; kill = k; tick = t; rst = r;
    model_update(s, k, t, r);
    sb_q.push_back({2'(m_state), 3'(m_anim), 10'(m_x), 9'(m_y), 1'(m_state != 0), 1'(m_done)});
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    step(0, 0, 0, 1);
    step(0, 0, 0, 0);
    checks++;
    if (obs !== IDLE_VEC) begin
      failures++;
      $display("FAIL reset_outputs actual=%h required=%h", obs, IDLE_VEC);
    end
    step(0, 0, 1, 0);
    checks++;
    if (obs !== IDLE_VEC) begin
      failures++;
      $display("FAIL tick_in_initial actual=%h required=%h", obs, IDLE_VEC);
    end
  endtask

  task automatic test_spawn_kill();
    step(1, 1, 0, 0);
    checks++;
    if (obs !== IDLE_VEC) begin
      failures++;
      $display("FAIL spawn_with_kill actual=%h required=%h", obs, IDLE_VEC);
    end
  endtask

  task automatic test_spawn_roll();
    logic [2:0] want_anim;
    step(1, 0, 0, 0);
    checks++;
    if (obs !== {2'd1, 3'd0, 10'd320, 9'd60, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL spawn_outputs actual=%h required=%h", obs, {2'd1, 3'd0, 10'd320, 9'd60, 1'b1, 1'b0});
    end
    for (int i = 1; i <= 139; i++) begin
      step(0, 0, 1, 0);
      if (i == 4 || i == 8 || i == 12 || i == 16) begin
        want_anim = 3'((i / 4) % 4);
        checks++;
        if (animation_state !== want_anim) begin
          failures++;
          $display("FAIL roll_anim tick=%0d actual=%0d required=%0d", i, animation_state, want_anim);
        end
      end
    end
    checks++;
    if ({state, posX, posY} !== {2'd1, 10'd598, 9'd60}) begin
      failures++;
      $display("FAIL roll_139 actual=%0d/%0d/%0d required=1/598/60", state, posX, posY);
    end
    step(0, 0, 1, 0);
    checks++;
    if (obs !== {2'd2, 3'd4, 10'd600, 9'd60, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL right_edge actual=%h required=%h", obs, {2'd2, 3'd4, 10'd600, 9'd60, 1'b1, 1'b0});
    end
  endtask

  task automatic test_fall_reverse();
    for (int i = 1; i <= 19; i++) begin
      step(0, 0, 1, 0);
      if (i == 4 || i == 8) begin
        checks++;
        if (animation_state !== ((i == 4) ? 3'd5 : 3'd4)) begin
          failures++;
          $display("FAIL fall_anim tick=%0d actual=%0d required=%0d", i, animation_state, (i == 4) ? 5 : 4);
        end
      end
    end
    step(0, 0, 1, 0);
    checks++;
    if (obs !== {2'd1, 3'd0, 10'd600, 9'd140, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL landing actual=%h required=%h", obs, {2'd1, 3'd0, 10'd600, 9'd140, 1'b1, 1'b0});
    end
    step(0, 0, 1, 0);
    checks++;
    if ({state, posX} !== {2'd1, 10'd598}) begin
      failures++;
      $display("FAIL roll_left actual=%0d/%0d required=1/598", state, posX);
    end
  endtask

  task automatic test_spawn_busy();
    step(1, 0, 0, 0);
    checks++;
    if (obs !== {2'd1, 3'd0, 10'd598, 9'd140, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL spawn_while_busy actual=%h required=%h", obs, {2'd1, 3'd0, 10'd598, 9'd140, 1'b1, 1'b0});
    end
  endtask

  task automatic test_floor_exit();
    logic [8:0] prev_y;
    bit seen;
    seen = 0;
    prev_y = posY;
    for (int i = 0; i < 3000 && !seen; i++) begin
      prev_y = posY;
      step(0, 0, 1, 0);
      if (done === 1'b1) seen = 1;
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL floor_exit_timeout actual=no_done required=done");
    end
    checks++;
    if (prev_y !== 9'd460) begin
      failures++;
      $display("FAIL exit_platform_y actual=%0d required=460", prev_y);
    end
    checks++;
    if (obs !== {2'd0, 3'd0, 10'd320, 9'd60, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL exit_outputs actual=%h required=%h", obs, {2'd0, 3'd0, 10'd320, 9'd60, 1'b0, 1'b1});
    end
    step(0, 0, 1, 0);
    checks++;
    if (obs !== IDLE_VEC) begin
      failures++;
      $display("FAIL done_one_cycle actual=%h required=%h", obs, IDLE_VEC);
    end
  endtask

  task automatic test_kill_mid_fall();
    step(1, 0, 0, 0);
    for (int i = 0; i < 145; i++) step(0, 0, 1, 0);
    checks++;
    if (state !== 2'd2) begin
      failures++;
      $display("FAIL pre_kill_state actual=%0d required=2", state);
    end
    step(0, 1, 1, 0);
    checks++;
    if (obs !== IDLE_VEC) begin
      failures++;
      $display("FAIL kill_mid_fall actual=%h required=%h", obs, IDLE_VEC);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      step(($urandom % 8) == 0, ($urandom % 128) == 0, ($urandom % 4) != 0, 1'b0);
    end
  endtask

  initial begin
    test_reset();
    test_spawn_kill();
    test_spawn_roll();
    test_fall_reverse();
    test_spawn_busy();
    test_floor_exit();
    test_kill_mid_fall();
    test_random();
    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/barrel_motion.md
Name: barrel_motion

Overview:
- Per-barrel motion and animation controller that produces the `state`, `animation_state`, `posX` and `posY` values consumed by the barrel renderer.
- Spawns a barrel at the top platform, rolls it along zig-zag platforms, drops it at each platform edge, and despawns it at the bottom edge.
- Advances only on the one-cycle frame `tick` from the game timing block.
- One instance per barrel; the game FSM drives `spawn`/`kill`.

Parameters:
- SPAWN_X, 320, spawn centre X in pixels (10-bit)
- SPAWN_Y, 60, spawn/top-platform centre Y in pixels (9-bit)
- LEFT_X, 40, leftmost centre X; a barrel rolling left falls on reaching it
- RIGHT_X, 600, rightmost centre X; a barrel rolling right falls on reaching it
- PITCH, 80, vertical distance between platforms; must be a multiple of FALL_STEP
- NUM_PLAT, 6, number of platforms; floor Y = SPAWN_Y + (NUM_PLAT-1)*PITCH = 460 (must be < 512)
- ROLL_STEP, 2, X pixels moved per tick while rolling
- FALL_STEP, 4, Y pixels moved per tick while falling
- ANIM_DIV, 4, ticks per animation frame (≥1)

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous active-high reset
- tick  input  1  one-cycle frame pulse; motion and animation advance only on it
- spawn  input  1  request to launch a barrel; honoured only in INITIAL
- kill  input  1  immediate despawn (barrel hit or game reset)
- state  output  2  00 INITIAL, 01 ROLLING, 10 FALLING (11 never driven)
- animation_state  output  3  000–011 ROLL1–4, 100 FALL1, 101 FALL2
- posX  output  10  barrel centre X
- posY  output  9  barrel centre Y
- busy  output  1  high when state ≠ INITIAL
- done  output  1  one-cycle pulse when the barrel leaves via the floor edge

Behaviour:
- All outputs are registered. Clock is `clk`; reset is synchronous and active-high on `rst`.
- Reset values:
  - state = INITIAL, animation_state = ROLL1
  - posX = SPAWN_X, posY = SPAWN_Y
  - busy = 0, done = 0
  - internal: dir = right, plat = 0, anim_cnt = 0, fall_target = SPAWN_Y
- Priority each cycle: rst > kill > spawn > tick.
- Any state: on `kill`, next cycle state = INITIAL, posX/posY = spawn values, animation_state = ROLL1, done = 0.
- INITIAL:
  - On `spawn` with no `kill`, next cycle: state = ROLLING, posX = SPAWN_X, posY = SPAWN_Y, dir = right, plat = 0, animation_state = ROLL1, anim_cnt = 0.
  - `tick` is ignored in INITIAL.
- ROLLING, on `tick`:
  - Compute nx = posX ± ROLL_STEP, computed 11 bits wide to avoid wrap.
  - dir = right and nx ≥ RIGHT_X: posX = RIGHT_X, edge reached.
  - dir = left and nx ≤ LEFT_X (including underflow): posX = LEFT_X, edge reached.
  - Otherwise posX = nx.
  - Edge reached with plat < NUM_PLAT-1: state = FALLING, fall_target = posY + PITCH, animation_state = FALL1, anim_cnt = 0.
  - Edge reached with plat = NUM_PLAT-1: state = INITIAL, done = 1 for one cycle, positions reload to spawn values.
- FALLING, on `tick`:
  - posY += FALL_STEP.
  - When the new posY = fall_target: state = ROLLING, dir flips, plat += 1, animation_state = ROLL1, anim_cnt = 0.
  - posX is held throughout the fall.
- Animation, on `tick` in ROLLING or FALLING when no state transition occurs that tick:
  - If anim_cnt = ANIM_DIV-1: anim_cnt = 0 and the frame advances.
    - ROLLING: ROLL1→2→3→4→1.
    - FALLING: FALL1↔FALL2.
  - Otherwise anim_cnt increments.
- `spawn` while busy is ignored and not queued.
- `done` is never asserted on `kill`.
- Unreachable state 11 recovers to INITIAL on the next clock.
- Motion latency: outputs update on the clk edge following the cycle in which `tick` is high.

Test Plan:
- Reset, then spawn: after the `rst` pulse, outputs are INITIAL/ROLL1/320/60, busy = 0. Pulse `spawn` → next cycle ROLLING, posX = 320, posY = 60, busy = 1.
- Roll to edge: after spawn, 139 ticks → posX = 598, ROLLING. The 140th tick → posX = 600, FALLING, FALL1.
- Fall and reverse: 20 further ticks → posY = 140, ROLLING, ROLL1. The next tick → posX = 598 (moving left).
- Animation: from ROLL1 with ANIM_DIV = 4, ticks 4/8/12/16 → ROLL2/ROLL3/ROLL4/ROLL1. In FALLING, tick 4 → FALL2 and tick 8 → FALL1.
- Floor exit: run to plat 5 (posY = 460, rolling left) until posX reaches 40 → state INITIAL, done high for exactly 1 cycle, posX/posY = 320/60.
- Kill and spawn priority:
  - `kill` mid-fall → INITIAL next cycle, done = 0.
  - `spawn` and `kill` together in INITIAL → remains INITIAL.
  - `spawn` while ROLLING → no change to position or state.
